// File: rtl/piso_shift_register_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
//   piso_state_e : frame FSM states (IDLE, SHIFT)
//   CNT_W        : bit-counter width for the default 32-bit word
//   MSB_FIRST /
//   LSB_FIRST    : bit-order selector values
//   cnt_width()  : bit-counter width for an arbitrary word length
package piso_shift_register_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = $clog2(DEF_DATA_W);

  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

  // The counter holds "bits still to send after the one on sout", so it
  // never exceeds DATA_W-1 and $clog2(DATA_W) bits are enough.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter for the PISO transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a frame; counter takes DATA_W-1
//   dec        : one more bit moved onto sout; count down
//   clr        : frame finished with no follow-on word
//   tc         : counter is zero (last bit is on sout while in SHIFT)
//   last       : registered end-of-frame flag, drives sout_last
module piso_bit_counter
  import piso_shift_register_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic tc,
  output logic last
);

  localparam int                  CNT_BITS = cnt_width(DATA_W);
  localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(DATA_W - 1);
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);

  logic [CNT_BITS-1:0] cnt_p1;
  logic                last_p1;

  // Stage p1: count register and terminal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      cnt_p1  <= LOAD_VAL;
      last_p1 <= 1'b0;
    end else if (dec && (cnt_p1 != '0)) begin
      cnt_p1  <= cnt_p1 - ONE;
      last_p1 <= (cnt_p1 == ONE);
    end else if (clr) begin
      cnt_p1  <= '0;
      last_p1 <= 1'b0;
    end
  end

  assign tc   = (cnt_p1 == '0);
  assign last = last_p1;

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter, sending end of the SIPO link.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : DATA_W-bit word, sampled only on the transfer edge
//   in_valid   : in_data is valid
//   in_ready   : a word can be accepted this cycle (combinational)
//   sout       : serial data bit, 0 whenever sout_valid is low
//   sout_valid : sout carries a frame bit
//   sout_last  : final bit of the frame is on sout
//   busy       : frame in progress (same as sout_valid)
// LSB_FIRST=0 sends bit DATA_W-1 first; LSB_FIRST=1 sends bit 0 first.
module piso_shift_register #(
  parameter int DATA_W    = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_last,
  output logic              busy
);
  import piso_shift_register_pkg::*;

  localparam bit LSB_ORDER = (LSB_FIRST != MSB_FIRST);

  piso_state_e       state_p1, state_nxt;
  logic [DATA_W-2:0] shreg_p1;
  logic              sout_p1;
  logic              vld_p1;
  logic              xfer;
  logic              cnt_load, cnt_dec, cnt_clr, cnt_tc, last_p1;

  // The bit leaving first goes straight to sout; the shift register only
  // ever holds the DATA_W-1 bits still to come.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_ORDER ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-2:0] rest_bits(input logic [DATA_W-1:0] w);
    return LSB_ORDER ? w[DATA_W-1:1] : w[DATA_W-2:0];
  endfunction

  function automatic logic next_bit(input logic [DATA_W-2:0] s);
    return LSB_ORDER ? s[0] : s[DATA_W-2];
  endfunction

  function automatic logic [DATA_W-2:0] advance(input logic [DATA_W-2:0] s);
    return LSB_ORDER ? (s >> 1) : (s << 1);
  endfunction

  // Ready again on the last bit so frames stream back to back.
  assign in_ready = (state_p1 == IDLE) || ((state_p1 == SHIFT) && last_p1);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p1;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    case (state_p1)
      IDLE: begin
        if (xfer) begin
          cnt_load  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!cnt_tc) begin
          cnt_dec = 1'b1;
        end else if (xfer) begin
          cnt_load = 1'b1;
        end else begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  piso_bit_counter #(
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .clr   (cnt_clr),
    .tc    (cnt_tc),
    .last  (last_p1)
  );

  // Stage p1: state, shift register and serial output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      shreg_p1 <= '0;
      sout_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (cnt_load) begin
        sout_p1  <= first_bit(in_data);
        shreg_p1 <= rest_bits(in_data);
        vld_p1   <= 1'b1;
      end else if (cnt_dec) begin
        sout_p1  <= next_bit(shreg_p1);
        shreg_p1 <= advance(shreg_p1);
      end else if (cnt_clr) begin
        sout_p1  <= 1'b0;
        shreg_p1 <= '0;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign sout       = sout_p1;
  assign sout_valid = vld_p1;
  assign sout_last  = last_p1;
  assign busy       = vld_p1;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench: a 32-bit MSB-first instance with a SIPO loopback and an
// 8-bit LSB-first instance, sharing clock and reset.
module tb_piso_shift_register;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_sout, a_sv, a_last, a_busy;

  logic [7:0]  b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_sout, b_sv, b_last, b_busy;

  logic [31:0] sipo = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Receiver model: 32-stage SIPO shifting MSB in from the right.
  always @(posedge clk) sipo <= {sipo[30:0], a_sout};

  piso_shift_register #(.DATA_W(32), .LSB_FIRST(1'b0)) dut_a (
    .clk (clk), .rst_n (rst_n), .in_data (a_data), .in_valid (a_valid),
    .in_ready (a_ready), .sout (a_sout), .sout_valid (a_sv),
    .sout_last (a_last), .busy (a_busy)
  );

  piso_shift_register #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_b (
    .clk (clk), .rst_n (rst_n), .in_data (b_data), .in_valid (b_valid),
    .in_ready (b_ready), .sout (b_sout), .sout_valid (b_sv),
    .sout_last (b_last), .busy (b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with dut_a idle. Sends one word, then scribbles
  // in_data so only the transfer-edge sample matters.
  task automatic frame_a(input logic [31:0] w, output logic [31:0] got,
                         output int nvld, output int lastpos, output int busy_bad);
    a_data  = w;
    a_valid = 1'b1;
    got = '0; nvld = 0; lastpos = -1; busy_bad = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_valid = 1'b0;
        a_data  = ~w;
      end
      got = {got[30:0], a_sout};
      if (a_sv) nvld++;
      if (a_last) lastpos = i;
      if (a_busy !== a_sv) busy_bad++;
    end
  endtask

  initial begin
    logic [31:0] got32;
    logic [63:0] got64;
    logic [7:0]  got8;
    int nvld, lastpos, busy_bad, rdy_hi, rdy_bad, resid;

    // Reset held with a word offered: nothing may start.
    a_valid = 1'b1; a_data = 32'h1234_5678;
    b_valid = 1'b1; b_data = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_sout",  a_sout, 0);
    check("rst_valid", a_sv,   0);
    check("rst_last",  a_last, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", a_ready, 1);
    check("rst_idle_valid", a_sv, 0);

    // Single frame 0x80000001, MSB first.
    frame_a(32'h8000_0001, got32, nvld, lastpos, busy_bad);
    check("f1_word",    got32,   32'h8000_0001);
    check("f1_nvld",    nvld,    32);
    check("f1_lastpos", lastpos, 32);
    check("f1_busy",    busy_bad, 0);
    @(negedge clk);
    check("f1_idle_valid", a_sv,   0);
    check("f1_idle_sout",  a_sout, 0);
    check("f1_idle_ready", a_ready, 1);

    // Loopback into the SIPO.
    frame_a(32'hDEAD_BEEF, got32, nvld, lastpos, busy_bad);
    check("lb_word", got32, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lb_sipo",  sipo, 32'hDEAD_BEEF);
    check("lb_valid", a_sv, 0);

    // Back-to-back: valid held high across two words.
    a_data = 32'hA5A5_A5A5; a_valid = 1'b1;
    got64 = '0; nvld = 0; rdy_hi = 0; rdy_bad = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 1)  a_data  = 32'h0000_FFFF;
      if (i == 33) a_valid = 1'b0;
      got64 = {got64[62:0], a_sout};
      if (a_sv) nvld++;
      if (a_ready) rdy_hi++;
      if (a_ready !== a_last) rdy_bad++;
    end
    check("b2b_word",   got64, 64'hA5A5_A5A5_0000_FFFF);
    check("b2b_nvld",   nvld, 64);
    check("b2b_rdy_hi", rdy_hi, 2);
    check("b2b_rdy_eq_last", rdy_bad, 0);
    @(negedge clk);
    check("b2b_idle_valid", a_sv, 0);

    // LSB-first 8-bit instance: 0x01 -> 1,0,0,0,0,0,0,0.
    b_data = 8'h01; b_valid = 1'b1;
    got8 = '0; nvld = 0; lastpos = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        b_valid = 1'b0;
        check("lsb_first_bit", b_sout, 1);
      end
      got8 = {b_sout, got8[7:1]};
      if (b_sv) nvld++;
      if (b_last) lastpos = i;
    end
    check("lsb_word",    got8, 8'h01);
    check("lsb_nvld",    nvld, 8);
    check("lsb_lastpos", lastpos, 8);
    @(negedge clk);
    check("lsb_idle_valid", b_sv, 0);

    // Mid-frame reset after 10 bits of 0xFFFFFFFF.
    a_data = 32'hFFFF_FFFF; a_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) a_valid = 1'b0;
    end
    check("mr_pre_valid", a_sv, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_sout",  a_sout, 0);
    check("mr_async_valid", a_sv,   0);
    check("mr_async_last",  a_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_sv || a_sout) resid++;
    end
    check("mr_residual", resid, 0);
    frame_a(32'h1234_5678, got32, nvld, lastpos, busy_bad);
    check("mr_next_word",    got32,   32'h1234_5678);
    check("mr_next_nvld",    nvld,    32);
    check("mr_next_lastpos", lastpos, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
